// File: rtl/ad9866_spi_arbiter_if.sv
// Command/status bundle between the AD9866 SPI arbiter and its requesters and SPI engine.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface ad9866_spi_arbiter_if;
    logic       init_done;
    logic [5:0] rx_gain;
    logic [5:0] tx_gain;
    logic       host_wr_valid;
    logic [4:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic       host_wr_ready;
    logic       spi_req;
    logic [4:0] spi_addr;
    logic [7:0] spi_data;
    logic       spi_ack;
    logic       spi_done;
    logic       busy;
    logic [5:0] rx_gain_applied;
    logic [5:0] tx_gain_applied;

    modport slave (
        input  init_done, rx_gain, tx_gain, host_wr_valid, host_wr_addr, host_wr_data,
               spi_ack, spi_done,
        output host_wr_ready, spi_req, spi_addr, spi_data, busy,
               rx_gain_applied, tx_gain_applied
    );

    modport master (
        output init_done, rx_gain, tx_gain, host_wr_valid, host_wr_addr, host_wr_data,
               spi_ack, spi_done,
        input  host_wr_ready, spi_req, spi_addr, spi_data, busy,
               rx_gain_applied, tx_gain_applied
    );
endinterface

// File: rtl/ad9866_spi_arbiter.sv
// Round-robin scheduler of RX gain, TX gain and host register writes onto the AD9866
// SPI engine's single command port; gain writes are coalesced to the latest value.
module ad9866_spi_arbiter #(
    parameter int         HOLDOFF_CYCLES = 4,
    parameter logic [4:0] RX_GAIN_ADDR   = 5'h09,
    parameter logic [4:0] TX_GAIN_ADDR   = 5'h0a
) (
    input  logic                    clk,
    input  logic                    reset,
    ad9866_spi_arbiter_if.slave     bus
);
    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
    localparam logic [4:0] MAX_HOST_ADDR = 5'h13;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
    typedef enum logic [1:0] {SRC_HOST, SRC_RX, SRC_TX} src_t;

    state_t           state;
    src_t             ptr;
    src_t             cmd_src;
    src_t             winner;
    logic             any_pend;
    logic [2:0]       pend;
    logic             rx_force;
    logic             tx_force;
    logic             init_q;
    logic [5:0]       cap_gain;
    logic [CNT_W-1:0] hold_cnt;
    logic             complete;

    function automatic src_t next_src(input src_t s);
        case (s)
            SRC_HOST: next_src = SRC_RX;
            SRC_RX:   next_src = SRC_TX;
            default:  next_src = SRC_HOST;
        endcase
    endfunction

    always_comb begin
        pend[SRC_HOST] = bus.host_wr_valid;
        pend[SRC_RX]   = rx_force | (bus.rx_gain != bus.rx_gain_applied);
        pend[SRC_TX]   = tx_force | (bus.tx_gain != bus.tx_gain_applied);
    end

    // Search starts at the pointer; first pending requester wins.
    always_comb begin
        src_t cand;
        winner   = SRC_HOST;
        any_pend = 1'b0;
        cand     = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!any_pend && pend[cand]) begin
                winner   = cand;
                any_pend = 1'b1;
            end
            cand = next_src(cand);
        end
    end

    // An ack and done arriving together in ISSUE count as a finished transfer.
    assign complete = ((state == S_ISSUE) && bus.spi_ack && bus.spi_done) ||
                      ((state == S_WAIT) && bus.spi_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            ptr                 <= SRC_HOST;
            cmd_src             <= SRC_HOST;
            rx_force            <= 1'b1;
            tx_force            <= 1'b1;
            init_q              <= 1'b0;
            cap_gain            <= '0;
            hold_cnt            <= '0;
            bus.spi_req         <= 1'b0;
            bus.spi_addr        <= '0;
            bus.spi_data        <= '0;
            bus.host_wr_ready   <= 1'b0;
            bus.busy            <= 1'b0;
            bus.rx_gain_applied <= '0;
            bus.tx_gain_applied <= '0;
        end else begin
            bus.host_wr_ready <= 1'b0;
            init_q            <= bus.init_done;
            // A falling init_done means the chip was re-initialised and lost its gains.
            if (init_q && !bus.init_done) begin
                rx_force <= 1'b1;
                tx_force <= 1'b1;
            end
            if (complete) begin
                if (cmd_src == SRC_RX) bus.rx_gain_applied <= cap_gain;
                if (cmd_src == SRC_TX) bus.tx_gain_applied <= cap_gain;
                bus.spi_req <= 1'b0;
                if (HOLDOFF_CYCLES > 0) begin
                    state    <= S_HOLD;
                    hold_cnt <= HOLD_LOAD;
                    bus.busy <= 1'b1;
                end else begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.init_done && any_pend) begin
                            ptr     <= next_src(winner);
                            cmd_src <= winner;
                            case (winner)
                                SRC_HOST: begin
                                    bus.host_wr_ready <= 1'b1;
                                    // Out-of-range host addresses are acknowledged and discarded.
                                    if (bus.host_wr_addr <= MAX_HOST_ADDR) begin
                                        bus.spi_addr <= bus.host_wr_addr;
                                        bus.spi_data <= bus.host_wr_data;
                                        bus.spi_req  <= 1'b1;
                                        bus.busy     <= 1'b1;
                                        state        <= S_ISSUE;
                                    end
                                end
                                SRC_RX: begin
                                    rx_force     <= 1'b0;
                                    cap_gain     <= bus.rx_gain;
                                    bus.spi_addr <= RX_GAIN_ADDR;
                                    bus.spi_data <= {2'b01, bus.rx_gain};
                                    bus.spi_req  <= 1'b1;
                                    bus.busy     <= 1'b1;
                                    state        <= S_ISSUE;
                                end
                                default: begin
                                    tx_force     <= 1'b0;
                                    cap_gain     <= bus.tx_gain;
                                    bus.spi_addr <= TX_GAIN_ADDR;
                                    bus.spi_data <= {2'b01, bus.tx_gain};
                                    bus.spi_req  <= 1'b1;
                                    bus.busy     <= 1'b1;
                                    state        <= S_ISSUE;
                                end
                            endcase
                        end
                    end
                    S_ISSUE: begin
                        if (bus.spi_ack) begin
                            bus.spi_req <= 1'b0;
                            state       <= S_WAIT;
                        end
                    end
                    S_HOLD: begin
                        if (hold_cnt == '0) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ad9866_spi_arbiter.sv
// Directed bench for ad9866_spi_arbiter: a small SPI engine model logs every command,
// and each step compares the log and status outputs against hand-computed values.
module tb_ad9866_spi_arbiter;
    logic clk = 1'b0;
    logic reset;
    ad9866_spi_arbiter_if bus ();

    ad9866_spi_arbiter #(.HOLDOFF_CYCLES(4), .RX_GAIN_ADDR(5'h09), .TX_GAIN_ADDR(5'h0a)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int         ncmp = 0;
    int         nerr = 0;
    int         cyc = 0;
    int         last_done = -100;
    int         rdy_cnt = 0;
    int         rdy0;
    int         eng_state;
    int         eng_cnt;
    logic [4:0] log_addr[$];
    logic [7:0] log_data[$];
    logic       log_rdy[$];
    int         log_gap[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: ack on the first cycle spi_req is seen, done three cycles later.
    initial begin
        bus.spi_ack  = 1'b0;
        bus.spi_done = 1'b0;
        eng_state    = 0;
        eng_cnt      = 0;
        forever begin
            @(negedge clk);
            bus.spi_ack  = 1'b0;
            bus.spi_done = 1'b0;
            if (reset === 1'b1) begin
                eng_state = 0;
            end else if (eng_state == 0) begin
                if (bus.spi_req === 1'b1) begin
                    log_addr.push_back(bus.spi_addr);
                    log_data.push_back(bus.spi_data);
                    log_rdy.push_back(bus.host_wr_ready);
                    log_gap.push_back(cyc - last_done - 1);
                    bus.spi_ack = 1'b1;
                    eng_state   = 1;
                    eng_cnt     = 0;
                end
            end else begin
                eng_cnt++;
                if (eng_cnt == 3) begin
                    bus.spi_done = 1'b1;
                    last_done    = cyc;
                    eng_state    = 0;
                end
            end
            if (bus.host_wr_ready === 1'b1) rdy_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input string tag);
        int t = 0;
        while (log_addr.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(log_addr.size() >= n), 32'd1);
    endtask

    task automatic chk_cmd(input string tag, input int idx, input logic [4:0] a, input logic [7:0] d);
        check(tag, {19'd0, log_addr[idx], log_data[idx]}, {19'd0, a, d});
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, "_req"},  32'(bus.spi_req), 32'd0);
        check({tag, "_addr"}, 32'(bus.spi_addr), 32'd0);
        check({tag, "_data"}, 32'(bus.spi_data), 32'd0);
        check({tag, "_rdy"},  32'(bus.host_wr_ready), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rxap"}, 32'(bus.rx_gain_applied), 32'd0);
        check({tag, "_txap"}, 32'(bus.tx_gain_applied), 32'd0);
    endtask

    initial begin
        int t;
        reset             = 1'b1;
        bus.init_done     = 1'b1;
        bus.rx_gain       = 6'd0;
        bus.tx_gain       = 6'd0;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_addr  = 5'h00;
        bus.host_wr_data  = 8'h00;
        tick(2);
        chk_reset_outputs("rst0");
        reset = 1'b0;

        // Forced writes after reset with both gains at zero.
        wait_log(2, "force_seen");
        tick(40);
        check("force_count", log_addr.size(), 2);
        chk_cmd("force_rx", 0, 5'h09, 8'h40);
        chk_cmd("force_tx", 1, 5'h0a, 8'h40);
        check("force_rxap", 32'(bus.rx_gain_applied), 32'd0);
        check("force_txap", 32'(bus.tx_gain_applied), 32'd0);

        // RX gain moves 5 -> 12 -> 20 while the first write is in flight.
        bus.rx_gain = 6'd5;
        wait_log(3, "coal_first_seen");
        bus.rx_gain = 6'd12;
        tick(1);
        bus.rx_gain = 6'd20;
        tick(50);
        check("coal_count", log_addr.size(), 4);
        chk_cmd("coal_first", 2, 5'h09, 8'h45);
        chk_cmd("coal_last", 3, 5'h09, 8'h54);
        check("coal_rxap", 32'(bus.rx_gain_applied), 32'd20);

        // Out-of-range host write is accepted and dropped; pointer must move to RX.
        rdy0 = rdy_cnt;
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = 5'h1f;
        bus.host_wr_data  = 8'h77;
        t = 0;
        while (bus.host_wr_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drop_rdy", 32'(bus.host_wr_ready), 32'd1);
        check("drop_req", 32'(bus.spi_req), 32'd0);
        check("drop_busy", 32'(bus.busy), 32'd0);
        bus.host_wr_addr = 5'h05;
        bus.host_wr_data = 8'h33;
        bus.rx_gain      = 6'd30;
        wait_log(6, "drop_next_seen");
        bus.host_wr_valid = 1'b0;
        tick(30);
        chk_cmd("drop_then_rx", 4, 5'h09, 8'h5e);
        chk_cmd("drop_then_host", 5, 5'h05, 8'h33);
        check("drop_host_rdy", 32'(log_rdy[5]), 32'd1);
        check("drop_rdy_pulses", rdy_cnt - rdy0, 2);

        // A lone TX write puts the pointer back at HOST.
        bus.tx_gain = 6'd9;
        wait_log(7, "tx9_seen");
        tick(30);
        chk_cmd("tx9", 6, 5'h0a, 8'h49);

        // All three requesters pending: HOST, RX, TX, HOST.
        rdy0 = rdy_cnt;
        bus.host_wr_valid = 1'b1;
        bus.host_wr_addr  = 5'h03;
        bus.host_wr_data  = 8'ha5;
        bus.rx_gain       = 6'd21;
        bus.tx_gain       = 6'd7;
        wait_log(8, "rot_first_seen");
        bus.host_wr_addr = 5'h04;
        bus.host_wr_data = 8'h5a;
        wait_log(11, "rot_all_seen");
        bus.host_wr_valid = 1'b0;
        tick(30);
        check("rot_count", log_addr.size(), 11);
        chk_cmd("rot_host1", 7, 5'h03, 8'ha5);
        chk_cmd("rot_rx", 8, 5'h09, 8'h55);
        chk_cmd("rot_tx", 9, 5'h0a, 8'h47);
        chk_cmd("rot_host2", 10, 5'h04, 8'h5a);
        check("rot_rdy_h1", 32'(log_rdy[7]), 32'd1);
        check("rot_rdy_rx", 32'(log_rdy[8]), 32'd0);
        check("rot_rdy_h2", 32'(log_rdy[10]), 32'd1);
        check("rot_gap_rx", log_gap[8], 5);
        check("rot_gap_tx", log_gap[9], 5);
        check("rot_gap_h2", log_gap[10], 5);
        check("rot_rdy_pulses", rdy_cnt - rdy0, 2);

        // No grants while init_done is low, even with gains changing.
        bus.init_done = 1'b0;
        bus.rx_gain   = 6'd33;
        bus.tx_gain   = 6'd40;
        tick(5);
        bus.rx_gain = 6'd34;
        tick(5);
        bus.rx_gain = 6'd33;
        tick(20);
        check("init_low_count", log_addr.size(), 11);
        check("init_low_req", 32'(bus.spi_req), 32'd0);
        bus.init_done = 1'b1;
        wait_log(13, "init_rise_seen");
        tick(30);
        chk_cmd("init_rx", 11, 5'h09, 8'h61);
        chk_cmd("init_tx", 12, 5'h0a, 8'h68);
        check("init_rxap", 32'(bus.rx_gain_applied), 32'd33);
        check("init_txap", 32'(bus.tx_gain_applied), 32'd40);

        // Re-initialisation with unchanged gains forces both to be rewritten.
        bus.init_done = 1'b0;
        tick(3);
        bus.init_done = 1'b1;
        wait_log(15, "reinit_seen");
        tick(30);
        check("reinit_count", log_addr.size(), 15);
        chk_cmd("reinit_rx", 13, 5'h09, 8'h61);
        chk_cmd("reinit_tx", 14, 5'h0a, 8'h68);

        // Asynchronous reset while waiting for spi_done.
        bus.rx_gain = 6'd50;
        wait_log(16, "rst_wr_seen");
        tick(1);
        check("rst_wait_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        tick(2);
        reset = 1'b0;
        wait_log(18, "rst_force_seen");
        tick(30);
        check("rst_force_count", log_addr.size(), 18);
        chk_cmd("rst_force_rx", 16, 5'h09, 8'h72);
        chk_cmd("rst_force_tx", 17, 5'h0a, 8'h68);
        check("rst_rxap", 32'(bus.rx_gain_applied), 32'd50);
        check("rst_txap", 32'(bus.tx_gain_applied), 32'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/ad9866_spi_arbiter.md
# ad9866_spi_arbiter

Schedules register writes to the AD9866 SPI engine on behalf of three requesters: RX gain, TX gain and host register writes. It sits between the gain and host-control logic and the SPI engine's single-command port. Gain writes are coalesced so that only the latest value is ever sent. Requesters are served round-robin, one SPI transaction at a time, with a programmable idle gap between transactions.

## Interface
Parameters:
- HOLDOFF_CYCLES, 4: idle clk cycles after each `spi_done` before the next grant (0 allowed).
- RX_GAIN_ADDR, 5'h09: register address for RX gain writes.
- TX_GAIN_ADDR, 5'h0a: register address for TX gain writes.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- init_done  in  1  level; the SPI engine's init sequence is complete. No grants while low.
- rx_gain  in  6  requested RX gain code.
- tx_gain  in  6  requested TX gain code.
- host_wr_valid  in  1  host write request; held until accepted.
- host_wr_addr  in  5  host register address.
- host_wr_data  in  8  host register data.
- host_wr_ready  out  1  one-cycle accept pulse for the host request.
- spi_req  out  1  command valid to the SPI engine.
- spi_addr  out  5  command register address.
- spi_data  out  8  command register data.
- spi_ack  in  1  one-cycle pulse; the engine has taken the command.
- spi_done  in  1  one-cycle pulse; the SPI transfer is complete.
- busy  out  1  high in any state other than IDLE.
- rx_gain_applied  out  6  last RX gain code completed on SPI.
- tx_gain_applied  out  6  last TX gain code completed on SPI.

## Operation
Reset values:
- `spi_req`=0, `spi_addr`=0, `spi_data`=0, `host_wr_ready`=0, `busy`=0.
- `rx_gain_applied`=0, `tx_gain_applied`=0.
- Round-robin pointer = HOST.
- `rx_force`=1, `tx_force`=1.
- State = IDLE.

Pending flags:
- `host_pend` = `host_wr_valid`.
- `rx_pend` = `rx_force` | (`rx_gain` != `rx_gain_applied`).
- `tx_pend` = `tx_force` | (`tx_gain` != `tx_gain_applied`).

Arbitration:
- Round-robin order is HOST → RX → TX → HOST.
- The search starts at the pointer. The first pending requester wins.
- After a grant, the pointer moves to the requester following the winner.

Grant actions:
- HOST grant: `spi_addr`/`spi_data` = host inputs; `host_wr_ready` pulses in the grant cycle.
- Host addresses above 5'h13 are accepted (ready pulse) and then dropped. No SPI command is issued, the pointer still advances, and the FSM stays in IDLE.
- RX/TX grant: `spi_addr` = RX_GAIN_ADDR/TX_GAIN_ADDR; `spi_data` = {2'b01, gain}.
- The gain value is captured at grant. Later changes to the gain input do not alter the in-flight command.
- The matching force flag clears at grant.

State machine:
- IDLE: if `init_done` and any pending → load the command and go to ISSUE.
- ISSUE: `spi_req`=1, with address and data stable. On `spi_ack` → WAIT.
- WAIT: `spi_req`=0. On `spi_done`:
  - the applied register is updated with the captured gain (gain commands only);
  - go to HOLD if HOLDOFF_CYCLES>0, else IDLE.
- HOLD: count HOLDOFF_CYCLES cycles, then go to IDLE.

Boundary rules:
- `spi_ack` and `spi_done` in the same ISSUE cycle: treat as complete and go directly to HOLD/IDLE.
- `spi_done` outside WAIT is ignored.
- If a gain input changes during a transaction, it re-pends by mismatch after completion. Only the latest value is written.
- If a gain input returns to the applied value before its grant, no write occurs.
- Falling edge of `init_done` sets `rx_force` and `tx_force` (the chip was re-initialised).
- An in-flight transaction still completes if `init_done` falls, but no new grant is made while `init_done` is low.
- Reset mid-transaction abandons the command immediately. All registers return to their reset values.

## Timing
- Grant-to-`spi_req` latency: `spi_req` is registered high the cycle after the IDLE evaluation cycle.
- `host_wr_ready` is registered and is high in that same cycle.
- Minimum spacing: from `spi_done` to the next `spi_req` is HOLDOFF_CYCLES+1 clk cycles.
- `spi_addr`/`spi_data` are stable from `spi_req` rising until the next grant.
- `busy` is registered and aligned with the state: high in ISSUE, WAIT and HOLD.

## Test plan
- Reset, `init_done`=1, `rx_gain`=0, `tx_gain`=0, engine acks and completes each command after 3 cycles → forced writes addr 09 data 8'h40, then addr 0a data 8'h40. Applied values stay 0 and no third command is issued.
- `rx_gain` changes 5→12→20 during one transaction → exactly one further write, data 8'h54. `rx_gain_applied`=20.
- Host, RX and TX all pending continuously → grants rotate HOST, RX, TX, HOST.
  - Each `host_wr_ready` pulse coincides with the `spi_req` rise.
  - Gap from `spi_done` to the next `spi_req` is 5 cycles (default HOLDOFF_CYCLES).
- Host write to address 5'h1f → `host_wr_ready` pulses, `spi_req` stays 0, and the pointer advances.
- `init_done` held low with gains changing → no `spi_req`.
  - `init_done` rises → RX write, then TX write.
  - `init_done` then falls and rises again with unchanged gains → both gains are rewritten.
- Assert reset while in WAIT → all outputs return to reset values within the same cycle (async). After reset release, both forced writes recur.
